// File: rtl/md5_pkg.sv
// Shared types, constants and the byte-lane helper for the MD5 padding front end.
package md5_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BLK_WORDS    = 16;
    localparam int unsigned LEN_W        = 64;
    localparam int unsigned BLK_BYTES    = 64;
    localparam int unsigned IDX_W        = $clog2(BLK_BYTES);
    localparam int unsigned LEN_BYTE_POS = 56;
    localparam logic [7:0]  PAD_BYTE     = 8'h80;

    // Word 0 is the leftmost element; byte 4k of the block sits in word k bits [7:0].
    typedef logic [0:BLK_WORDS-1][WORD_W-1:0] blk_t;

    typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT} state_t;

    function automatic blk_t put_byte(blk_t blk, logic [IDX_W-1:0] idx, logic [7:0] data);
        blk[idx[IDX_W-1:2]][{idx[1:0], 3'b000} +: 8] = data;
        return blk;
    endfunction

endpackage

// File: rtl/md5_pad.sv
// Packs a byte stream into MD5-padded 512-bit blocks and hands them to the core
// over a valid/ready handshake, flagging the block that carries the length.
module md5_pad
    import md5_pkg::*;
(
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [7:0]                          in_data_i,
    input  logic                                in_valid_i,
    input  logic                                in_last_i,
    input  logic                                in_empty_i,
    output logic                                in_ready_o,
    output logic [0:BLK_WORDS-1][WORD_W-1:0]    blk_o,
    output logic                                blk_valid_o,
    input  logic                                blk_ready_i,
    output logic                                blk_last_o
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   bitlen_q, bitlen_d;
    blk_t               blk_q, blk_d;
    logic               need_pad80_q, need_pad80_d;
    logic               need_len_q, need_len_d;
    logic               last_q, last_d;
    logic               seen_last_q, seen_last_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_FILL;
            idx_q        <= '0;
            bitlen_q     <= '0;
            blk_q        <= '0;
            need_pad80_q <= 1'b0;
            need_len_q   <= 1'b0;
            last_q       <= 1'b0;
            seen_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bitlen_q     <= bitlen_d;
            blk_q        <= blk_d;
            need_pad80_q <= need_pad80_d;
            need_len_q   <= need_len_d;
            last_q       <= last_d;
            seen_last_q  <= seen_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bitlen_d     = bitlen_q;
        blk_d        = blk_q;
        need_pad80_d = need_pad80_q;
        need_len_d   = need_len_q;
        last_d       = last_q;
        seen_last_d  = seen_last_q;

        unique case (state_q)
            S_FILL: begin
                if (in_valid_i) begin
                    blk_d    = put_byte(blk_q, idx_q, in_data_i);
                    bitlen_d = bitlen_q + LEN_W'(8);
                    // idx wraps to 0 after byte 63; the handshake clears it anyway
                    idx_d    = idx_q + IDX_W'(1);
                    if (in_last_i) begin
                        need_pad80_d = 1'b1;
                        need_len_d   = 1'b1;
                        seen_last_d  = 1'b1;
                    end
                    if (idx_q == IDX_W'(BLK_BYTES - 1)) begin
                        state_d = S_EMIT;
                        last_d  = 1'b0;
                    end else if (in_last_i) begin
                        state_d = S_PAD;
                    end
                end else if (in_empty_i && idx_q == '0 && bitlen_q == '0) begin
                    state_d      = S_PAD;
                    need_pad80_d = 1'b1;
                    need_len_d   = 1'b1;
                    seen_last_d  = 1'b1;
                end
            end
            S_PAD: begin
                state_d = S_EMIT;
                if (need_pad80_q) begin
                    blk_d        = put_byte(blk_q, idx_q, PAD_BYTE);
                    need_pad80_d = 1'b0;
                end
                // Length fits only if the marker landed before byte 56 (or was already emitted)
                if (!need_pad80_q || idx_q <= IDX_W'(LEN_BYTE_POS - 1)) begin
                    blk_d[BLK_WORDS-2] = bitlen_q[WORD_W-1:0];
                    blk_d[BLK_WORDS-1] = bitlen_q[LEN_W-1:WORD_W];
                    need_len_d         = 1'b0;
                    last_d             = 1'b1;
                end else begin
                    last_d = 1'b0;
                end
            end
            S_EMIT: begin
                if (blk_ready_i) begin
                    blk_d  = '0;
                    idx_d  = '0;
                    last_d = 1'b0;
                    if (need_pad80_q || need_len_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                        if (seen_last_q) begin
                            bitlen_d    = '0;
                            seen_last_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign in_ready_o  = (state_q == S_FILL);
    assign blk_valid_o = (state_q == S_EMIT);
    assign blk_o       = blk_q;
    assign blk_last_o  = last_q;

endmodule

// File: tb/tb_md5_pad.sv
// Self-checking bench for md5_pad: whole-message MD5 padding model plus directed literal checks.
module tb_md5_pad;
    import md5_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] in_data_i = 8'h00;
    logic       in_valid_i = 1'b0;
    logic       in_last_i = 1'b0;
    logic       in_empty_i = 1'b0;
    logic       in_ready_o;
    blk_t       blk_o;
    logic       blk_valid_o;
    logic       blk_ready_i = 1'b0;
    logic       blk_last_o;

    md5_pad dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_last_i  (in_last_i),
        .in_empty_i (in_empty_i),
        .in_ready_o (in_ready_o),
        .blk_o      (blk_o),
        .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i),
        .blk_last_o (blk_last_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   hs_cyc = 0;
    logic rdy_rand = 1'b0;
    logic rdy_force = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #2;
        blk_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: standard MD5 padding of the whole message, cut into 64-byte blocks
    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        blk_t b;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    bq_t  msg;
    int   emitted = 0;

    function automatic blk_t chunk(input bq_t q, input int s);
        blk_t b = '0;
        for (int i = 0; i < 64; i++) b[i / 4][(i % 4) * 8 +: 8] = q[s + i];
        return b;
    endfunction

    task automatic model_finish();
        bq_t         p = msg;
        logic [63:0] bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bits[i * 8 +: 8]);
        for (int c = emitted; c < p.size(); c += 64)
            exp_q.push_back('{b: chunk(p, c), last: (c + 64 == p.size())});
        msg.delete();
        emitted = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            exp_q.delete();
            msg.delete();
            emitted = 0;
        end else begin
            if (blk_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("blk_unexpected", 512'(blk_valid_o), 512'd0);
                end else begin
                    chk("blk_data", blk_o, exp_q[0].b);
                    chk("blk_last", 512'(blk_last_o), 512'(exp_q[0].last));
                    if (blk_ready_i) void'(exp_q.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) begin
                msg.push_back(in_data_i);
                if (in_last_i) model_finish();
                else if (msg.size() - emitted == 64) begin
                    exp_q.push_back('{b: chunk(msg, emitted), last: 1'b0});
                    emitted += 64;
                end
            end else if (in_empty_i && in_ready_o && msg.size() == 0) begin
                model_finish();
            end
        end
    end

    // Presents one byte (or an empty pulse) until taken; called at posedge+1
    task automatic send_item(input logic [7:0] d, input logic last, input logic empty);
        int n = 0;
        in_valid_i = !empty;
        in_empty_i = empty;
        in_data_i  = d;
        in_last_i  = last;
        while (1) begin
            @(negedge clk);
            if (in_ready_o) break;
            n++;
            if (n > 400) break;
        end
        if (!in_ready_o) chk("accept_timeout", 512'(in_ready_o), 512'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_empty_i = 1'b0;
        in_last_i  = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_msg(input int n, input int base, input logic rnd);
        if (n == 0) send_item(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < n; i++)
            send_item(rnd ? 8'($urandom) : 8'(base + i), (i == n - 1), 1'b0);
    endtask

    task automatic wait_valid(output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!blk_valid_o && n < 300);
        chk("valid_seen", 512'(blk_valid_o), 512'd1);
        at = cyc;
    endtask

    task automatic handshake();
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        rdy_force = 1'b0;
    endtask

    int   at;
    blk_t e;

    initial begin
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 512'(blk_valid_o), 512'd0);
        chk("rst_ready", 512'(in_ready_o), 512'd1);
        chk("rst_last", 512'(blk_last_o), 512'd0);
        chk("rst_blk", blk_o, 512'd0);
        @(posedge clk);
        #1 rst_i = 1'b1;

        // Empty message
        send_msg(0, 0, 1'b0);
        wait_valid(at);
        e = '0;
        e[0] = 32'h0000_0080;
        chk("empty_blk", blk_o, e);
        chk("empty_last", 512'(blk_last_o), 512'd1);
        handshake();

        // "abc" with latency
        send_msg(3, 8'h61, 1'b0);
        wait_valid(at);
        chk("abc_latency", 512'(at - acc_cyc), 512'd2);
        chk("abc_w0", 512'(blk_o[0]), 512'h8063_6261);
        chk("abc_w14", 512'(blk_o[14]), 512'h18);
        chk("abc_w15", 512'(blk_o[15]), 512'h0);
        chk("abc_last", 512'(blk_last_o), 512'd1);
        handshake();

        // 55 bytes: marker and length share one block
        send_msg(55, 0, 1'b0);
        wait_valid(at);
        chk("m55_w13", 512'(blk_o[13]), 512'h8036_3534);
        chk("m55_w14", 512'(blk_o[14]), 512'h1B8);
        chk("m55_last", 512'(blk_last_o), 512'd1);
        handshake();

        // 56 bytes: length pushed into an extra block
        send_msg(56, 0, 1'b0);
        wait_valid(at);
        chk("m56a_w14", 512'(blk_o[14]), 512'h80);
        chk("m56a_w15", 512'(blk_o[15]), 512'h0);
        chk("m56a_last", 512'(blk_last_o), 512'd0);
        handshake();
        wait_valid(at);
        chk("m56b_latency", 512'(at - hs_cyc), 512'd2);
        e = '0;
        e[14] = 32'h1C0;
        chk("m56b_blk", blk_o, e);
        chk("m56b_last", 512'(blk_last_o), 512'd1);
        handshake();

        // 64 bytes, then a fresh one-byte message
        send_msg(64, 0, 1'b0);
        wait_valid(at);
        chk("m64a_w15", 512'(blk_o[15]), 512'h3F3E_3D3C);
        chk("m64a_last", 512'(blk_last_o), 512'd0);
        handshake();
        wait_valid(at);
        chk("m64b_w0", 512'(blk_o[0]), 512'h80);
        chk("m64b_w14", 512'(blk_o[14]), 512'h200);
        chk("m64b_last", 512'(blk_last_o), 512'd1);
        handshake();
        send_msg(1, 8'h61, 1'b0);
        wait_valid(at);
        chk("a_w0", 512'(blk_o[0]), 512'h8061);
        chk("a_w14", 512'(blk_o[14]), 512'h8);
        handshake();

        // Backpressure: block held, extra bytes refused
        send_msg(3, 8'h61, 1'b0);
        wait_valid(at);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid_i = 1'b1;
            in_data_i  = 8'hAA;
            @(negedge clk);
            chk("bp_w0", 512'(blk_o[0]), 512'h8063_6261);
            chk("bp_last", 512'(blk_last_o), 512'd1);
            chk("bp_ready", 512'(in_ready_o), 512'd0);
        end
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        handshake();
        send_msg(1, 8'h61, 1'b0);
        wait_valid(at);
        chk("bp_next_w0", 512'(blk_o[0]), 512'h8061);
        handshake();

        // Reset mid-fill
        for (int i = 0; i < 10; i++) send_item(8'(i + 1), 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 512'(blk_valid_o), 512'd0);
        chk("mid_rst_ready", 512'(in_ready_o), 512'd1);
        chk("mid_rst_blk", blk_o, 512'd0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        send_msg(3, 8'h61, 1'b0);
        wait_valid(at);
        chk("post_rst_w0", 512'(blk_o[0]), 512'h8063_6261);
        chk("post_rst_w14", 512'(blk_o[14]), 512'h18);
        handshake();

        // Random messages under random backpressure
        rdy_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(0, 3);
                1:       len = 55 + $urandom_range(0, 10);
                2:       len = 119 + $urandom_range(0, 10);
                default: len = $urandom_range(0, 150);
            endcase
            send_msg(len, 0, 1'b1);
        end
        begin
            int n = 0;
            while ((exp_q.size() != 0 || !in_ready_o) && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("drain", 512'(exp_q.size()), 512'd0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
